// File: rtl/div_sched_pkg.sv
// Shared types and helpers for the round-robin division scheduler.
// Default requester/divider geometry lives here because the tag layout
// (ID_W) and the arbiter width depend on it; the top-level parameters
// must match these values.
// Optional feature macro: DIV_ZERO_EN. When it is defined, each tag carries
// a divide-by-zero flag.
package div_sched_pkg;

    localparam int unsigned SCHED_N_REQ   = 3;
    localparam int unsigned SCHED_WIDTH   = 8;
    localparam int unsigned SCHED_STEPS   = 8;
    localparam int unsigned SCHED_MAX_OUT = 4;
    localparam int unsigned ID_W          = (SCHED_N_REQ > 1) ? $clog2(SCHED_N_REQ) : 1;

    // Travels alongside the divider pipeline; the payload is not reset.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
`ifdef DIV_ZERO_EN
        logic            zero;
`endif
    } div_tag_t;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] idx;
    } rr_pick_t;

    // Round-robin arbiter: first set bit of elig, searching from ptr upward
    // and wrapping modulo SCHED_N_REQ.
    function automatic rr_pick_t rr_pick(input logic [SCHED_N_REQ-1:0] elig,
                                         input logic [ID_W-1:0]        ptr);
        rr_pick_t    r;
        int unsigned idx;
        r = '0;
        for (int unsigned k = 0; k < SCHED_N_REQ; k++) begin
            idx = (32'(ptr) + k) % SCHED_N_REQ;
            if (!r.found && elig[ID_W'(idx)]) begin
                r.found = 1'b1;
                r.idx   = ID_W'(idx);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/div_tag_pipe.sv
// STEPS-deep shift register of div_tag_t. Tags entering with an issue
// leave exactly STEPS cycles later, lined up with the divider output.
// Only the valid bits are reset; id/zero payload bits are don't-care
// whenever the valid bit next to them is low.
// Optional feature macro: DIV_ZERO_EN (adds the zero flag to the payload).
// Ports:
//   clk    in   clock
//   nrst   in   async active-low reset
//   tag_i  in   tag entering on an issue (valid=0 on idle cycles)
//   tag_o  out  tag leaving after STEPS cycles
module div_tag_pipe
    import div_sched_pkg::*;
#(
    parameter int unsigned STEPS = SCHED_STEPS
) (
    input  logic     clk,
    input  logic     nrst,
    input  div_tag_t tag_i,
    output div_tag_t tag_o
);

    logic [STEPS-1:0] vld_q;
    logic [ID_W-1:0]  id_q [STEPS];
`ifdef DIV_ZERO_EN
    logic [STEPS-1:0] zero_q;
`endif

    // Valid chain, reset so no phantom tags emerge after reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= tag_i.valid;
            for (int unsigned i = 1; i < STEPS; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Payload chain, deliberately without reset.
    always_ff @(posedge clk) begin
        id_q[0] <= tag_i.id;
        for (int unsigned i = 1; i < STEPS; i++) begin
            id_q[i] <= id_q[i-1];
        end
`ifdef DIV_ZERO_EN
        zero_q[0] <= tag_i.zero;
        for (int unsigned i = 1; i < STEPS; i++) begin
            zero_q[i] <= zero_q[i-1];
        end
`endif
    end

    assign tag_o.valid = vld_q[STEPS-1];
    assign tag_o.id    = id_q[STEPS-1];
`ifdef DIV_ZERO_EN
    assign tag_o.zero  = zero_q[STEPS-1];
`endif

endmodule

// File: rtl/div_rr_scheduler.sv
// Round-robin scheduler that shares one pipelined unsigned divider among
// N_REQ requesters. It grants at most one request per cycle. Each issue
// is tagged with the requester ID, and each quotient is routed back with
// that ID. Per-requester in-flight work is capped at MAX_OUT.
// Optional feature macro: DIV_ZERO_EN (flags divide-by-zero, forces an
// all-ones quotient and rsp_err=1).
// Ports:
//   clk, nrst        clock, async active-low reset
//   req_valid        per-requester operand-valid
//   req_dividend     packed dividends, slice i = requester i
//   req_divisor      packed divisors,  slice i = requester i
//   req_ready        combinational one-hot grant (zero when nobody is eligible)
//   div_dividend     combinational operand mux to the divider
//   div_divisor      combinational operand mux to the divider
//   div_din_valid    combinational issue strobe to the divider
//   div_quotient     quotient from the divider
//   div_dout_valid   output strobe from the divider
//   rsp_valid        registered response strobe
//   rsp_id           registered requester index of the response
//   rsp_quotient     registered quotient
//   rsp_err          registered divide-by-zero flag (0 without DIV_ZERO_EN)
//   tag_err          sticky: divider output did not line up with a tag
module div_rr_scheduler
    import div_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = SCHED_N_REQ,
    parameter int unsigned WIDTH   = SCHED_WIDTH,
    parameter int unsigned STEPS   = SCHED_STEPS,
    parameter int unsigned MAX_OUT = SCHED_MAX_OUT
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_dividend,
    input  logic [N_REQ*WIDTH-1:0] req_divisor,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       div_dividend,
    output logic [WIDTH-1:0]       div_divisor,
    output logic                   div_din_valid,
    input  logic [STEPS-1:0]       div_quotient,
    input  logic                   div_dout_valid,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [STEPS-1:0]       rsp_quotient,
    output logic                   rsp_err,
    output logic                   tag_err
);

    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0] cnt_q [N_REQ];
    logic [CNT_W-1:0] cnt_d [N_REQ];
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0] elig;
    rr_pick_t         pick;
    div_tag_t         tag_in, tag_out;

    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [STEPS-1:0] rsp_quot_q, rsp_quot_d;
    logic             tag_err_q, tag_err_d;
`ifdef DIV_ZERO_EN
    logic             rsp_err_q, rsp_err_d;
`endif

    // Arbitration, operand mux, and issue tag.
    always_comb begin
        req_ready     = '0;
        div_dividend  = '0;
        div_divisor   = '0;
        div_din_valid = 1'b0;
        ptr_d         = ptr_q;
        tag_in        = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
        end
        pick = rr_pick(elig, ptr_q);
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick.found && (pick.idx == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                div_dividend = req_dividend[i*WIDTH +: WIDTH];
                div_divisor  = req_divisor[i*WIDTH +: WIDTH];
            end
        end
        if (pick.found) begin
            div_din_valid = 1'b1;
            ptr_d         = (pick.idx == ID_W'(N_REQ - 1)) ? '0 : pick.idx + 1'b1;
            tag_in.valid  = 1'b1;
            tag_in.id     = pick.idx;
`ifdef DIV_ZERO_EN
            tag_in.zero   = (div_divisor == '0);
`endif
        end
    end

    div_tag_pipe #(
        .STEPS (STEPS)
    ) u_tag_pipe (
        .clk   (clk),
        .nrst  (nrst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // Response capture and tag/divider alignment check.
    always_comb begin
        rsp_valid_d = tag_out.valid && div_dout_valid;
        rsp_id_d    = rsp_id_q;
        rsp_quot_d  = rsp_quot_q;
        tag_err_d   = tag_err_q | (tag_out.valid ^ div_dout_valid);
`ifdef DIV_ZERO_EN
        rsp_err_d   = rsp_err_q;
`endif
        if (rsp_valid_d) begin
            rsp_id_d   = tag_out.id;
            rsp_quot_d = div_quotient;
`ifdef DIV_ZERO_EN
            rsp_err_d  = tag_out.zero;
            if (tag_out.zero) begin
                rsp_quot_d = '1;
            end
`endif
        end
    end

    // In-flight counters: grant increments, the registered response decrements.
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if ((pick.found && (pick.idx == ID_W'(i))) &&
                !(rsp_valid_q && (rsp_id_q == ID_W'(i)))) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!(pick.found && (pick.idx == ID_W'(i))) &&
                         (rsp_valid_q && (rsp_id_q == ID_W'(i)))) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_quot_q  <= '0;
            tag_err_q   <= 1'b0;
`ifdef DIV_ZERO_EN
            rsp_err_q   <= 1'b0;
`endif
            for (int unsigned i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_quot_q  <= rsp_quot_d;
            tag_err_q   <= tag_err_d;
`ifdef DIV_ZERO_EN
            rsp_err_q   <= rsp_err_d;
`endif
            for (int unsigned i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_quotient = rsp_quot_q;
    assign tag_err      = tag_err_q;
`ifdef DIV_ZERO_EN
    assign rsp_err      = rsp_err_q;
`else
    assign rsp_err      = 1'b0;
`endif

endmodule
